// File: rtl/bomb_controller.sv
// rtl/bomb_controller.sv - bomb slot FSMs, placement arbitration, explosion events and sprite hit test.
// Optional blinking of nearly-expired bombs is enabled with `define BOMB_BLINK_EN.
module bomb_controller #(
    parameter int NUM_BOMBS    = 4,
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30,
    parameter int TILE         = 28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       place_req,
    input  logic [4:0] place_gx,
    input  logic [4:0] place_gy,
    output logic       place_ack,
    output logic       place_nack,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       bomb_on,
    output logic [4:0] sprite_row,
    output logic [4:0] sprite_col,
    output logic       explode_valid,
    output logic [4:0] explode_gx,
    output logic [4:0] explode_gy,
    output logic [3:0] active_count
);

    localparam int CNT_MAX = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FUSE    = 2'd1,
        S_EXPLODE = 2'd2
    } slot_state_e;

    slot_state_e          state_q [NUM_BOMBS];
    slot_state_e          state_d [NUM_BOMBS];
    logic [CW-1:0]        cnt_q   [NUM_BOMBS];
    logic [CW-1:0]        cnt_d   [NUM_BOMBS];
    logic [4:0]           gx_q    [NUM_BOMBS];
    logic [4:0]           gx_d    [NUM_BOMBS];
    logic [4:0]           gy_q    [NUM_BOMBS];
    logic [4:0]           gy_d    [NUM_BOMBS];
    logic [NUM_BOMBS-1:0] pend_q, pend_d;

    logic [NUM_BOMBS-1:0] load_vec, ev_sel, visible, in_cell;
    logic [4:0]           col_off [NUM_BOMBS];
    logic [4:0]           row_off [NUM_BOMBS];
    logic                 slot_free, dup_cell, accept;

    logic       ack_q, ack_d, nack_q, nack_d;
    logic       bomb_on_q, bomb_on_d;
    logic [4:0] row_q, row_d, col_q, col_d;

    // Lowest IDLE slot is the candidate; any FUSE slot on the same cell vetoes the request.
    always_comb begin
        load_vec  = '0;
        slot_free = 1'b0;
        dup_cell  = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (!slot_free && state_q[i] == S_IDLE) begin
                load_vec[i] = 1'b1;
                slot_free   = 1'b1;
            end
            if (state_q[i] == S_FUSE && gx_q[i] == place_gx && gy_q[i] == place_gy) begin
                dup_cell = 1'b1;
            end
        end
        accept = place_req && slot_free && !dup_cell;
        ack_d  = accept;
        nack_d = place_req && !accept;
    end

    always_comb begin
        ev_sel        = '0;
        explode_valid = 1'b0;
        explode_gx    = '0;
        explode_gy    = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (!explode_valid && pend_q[i]) begin
                ev_sel[i]     = 1'b1;
                explode_valid = 1'b1;
                explode_gx    = gx_q[i];
                explode_gy    = gy_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        pend_d  = pend_q & ~ev_sel;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            case (state_q[i])
                S_IDLE: begin
                    if (accept && load_vec[i]) begin
                        state_d[i] = S_FUSE;
                        cnt_d[i]   = CW'(FUSE_FRAMES);
                        gx_d[i]    = place_gx;
                        gy_d[i]    = place_gy;
                    end
                end
                S_FUSE: begin
                    if (frame_tick) begin
                        if (cnt_q[i] == CW'(1)) begin
                            state_d[i] = S_EXPLODE;
                            cnt_d[i]   = CW'(BLAST_FRAMES);
                            pend_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                end
                S_EXPLODE: begin
                    if (frame_tick) begin
                        if (cnt_q[i] == CW'(1)) begin
                            state_d[i] = S_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

`ifdef BOMB_BLINK_EN
    logic [2:0] frame_cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt_q <= '0;
        end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 3'd1;
        end
    end
`endif

    // Per-slot hit test; offsets are only meaningful when in_cell is set.
    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
        logic [15:0] x0, y0, dx, dy;
        assign x0 = 16'(gx_q[g]) * 16'(TILE);
        assign y0 = 16'(gy_q[g]) * 16'(TILE);
        assign dx = 16'(DrawX) - x0;
        assign dy = 16'(DrawY) - y0;
`ifdef BOMB_BLINK_EN
        assign visible[g] = !((32'(cnt_q[g]) <= 30) && frame_cnt_q[2]);
`else
        assign visible[g] = 1'b1;
`endif
        assign in_cell[g] = (state_q[g] == S_FUSE) && visible[g]
                          && (16'(DrawX) >= x0) && (dx < 16'(TILE))
                          && (16'(DrawY) >= y0) && (dy < 16'(TILE));
        assign col_off[g] = dx[4:0];
        assign row_off[g] = dy[4:0];
    end

    always_comb begin
        bomb_on_d = 1'b0;
        row_d     = '0;
        col_d     = '0;
        for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
            if (in_cell[i]) begin
                bomb_on_d = 1'b1;
                row_d     = row_off[i];
                col_d     = col_off[i];
            end
        end
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (state_q[i] != S_IDLE) begin
                active_count = active_count + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                gx_q[i]    <= '0;
                gy_q[i]    <= '0;
            end
            pend_q    <= '0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            bomb_on_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            bomb_on_q <= bomb_on_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

    assign place_ack  = ack_q;
    assign place_nack = nack_q;
    assign bomb_on    = bomb_on_q;
    assign sprite_row = row_q;
    assign sprite_col = col_q;

endmodule
